alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered successor to the 4-bit combinational ALU.
//  Accepts one operation per handshake, registers the result, and holds it until the consumer takes it.
//  Adds OR/XOR, an internal accumulator, a zero flag and valid/ready flow control on both sides.
//  Sits between the operand source and result sink in the datapath.
// PARAMETERS
//  W        4   operand/result width in bits (W >= 2)
// PORTS
//  clk        in   1   single clock; all state updates on the rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   operand/op word valid
//  in_ready   out  1   block can accept a word this cycle
//  a          in   W   operand A, unsigned
//  b          in   W   operand B, unsigned
//  op         in   3   operation select (see BEHAVIOUR)
//  out_valid  out  1   result registers hold an untaken result
//  out_ready  in   1   sink takes the result this cycle
//  result     out  W   registered result
//  c_out      out  1   carry out (ADD, SUB, ACC_ADD); 0 for all other ops
//  gt, eq, lt out  1   unsigned A vs B compare; one-hot for CMP, all 0 for other ops
//  zero       out  1   result == 0
//  acc        out  W   current accumulator value
// BEHAVIOUR
//  Ops:
//   000 ADD    : {c_out,result} = a + b
//   001 SUB    : {c_out,result} = a + ~b + 1
//                c_out = 1 means no borrow (a >= b)
//   010 CMP    : result = 0; gt/eq/lt per unsigned a vs b
//   011 AND    : result = a & b
//   100 OR     : result = a | b
//   101 XOR    : result = a ^ b
//   110 ACC_ADD: {c_out,result} = acc + b; a is ignored; acc <= result
//   111 ACC_CLR: result = 0; acc <= 0
//  Arithmetic is modulo 2^W. Carry is bit W of the (W+1)-bit sum.
//  Handshake:
//   in_ready = !out_valid || out_ready (combinational; no bubble when draining).
//   A word is accepted on a cycle with in_valid && in_ready.
//   On accept, result and all flags register on that edge.
//   out_valid goes to 1 at that edge: latency is 1 cycle.
//   If out_valid && out_ready && no accept this cycle, out_valid goes to 0.
//   While out_valid && !out_ready: result, flags and acc hold; in_ready = 0.
//   Simultaneous take and accept: the new result replaces the old one and out_valid stays 1.
//  acc changes only on an accepted ACC_ADD or ACC_CLR. Other ops leave it unchanged.
//  Reset (may assert mid-operation; it overrides a concurrent accept and discards any pending result):
//   out_valid = 0, result = 0, c_out = 0, gt = eq = lt = 0, zero = 1, acc = 0.
//  Outputs are registered. zero is derived from the registered result.
//  Inputs while in_valid = 0 are don't-care and must not change state.
// TESTING (W=4)
//  1. ADD a=9, b=8, out_ready=1 -> next cycle result=1, c_out=1, zero=0, out_valid=1.
//  2. SUB a=3, b=5 -> result=14, c_out=0.
//     SUB a=5, b=5 -> result=0, c_out=1, zero=1.
//  3. CMP a=7, b=2 -> gt=1, eq=0, lt=0, result=0.
//     Then AND 12&10 -> result=8, gt=eq=lt=0.
//  4. Backpressure: ADD 1+1 with out_ready=0 for 3 cycles while in_valid stays high with OR 3|4.
//     -> result=2 held, in_ready=0.
//     out_ready=1 -> OR accepted same cycle; next cycle result=7.
//  5. ACC_CLR, then ACC_ADD b=6, ACC_ADD b=11 back-to-back
//     -> results 0, 6, 1 (c_out=1 on the last); acc=1.
//  6. Assert rst while out_valid=1 and acc=9 with a valid word presented
//     -> next cycle out_valid=0, acc=0, zero=1, word not accepted.

Source files
------------

// File: rtl/alu_pipe.sv
// Registered W-bit ALU with accumulator, compare flags and valid/ready on both sides.
// Latency: 1 cycle from accept to out_valid; a new word may be accepted on the same cycle the old result drains.
// Backpressure: in_ready = !out_valid || out_ready, so a stalled result holds every output and blocks input.
module alu_pipe #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         c_out,
    output logic         gt,
    output logic         eq,
    output logic         lt,
    output logic         zero,
    output logic [W-1:0] acc
);

    typedef enum logic [2:0] {
        OP_ADD     = 3'b000,
        OP_SUB     = 3'b001,
        OP_CMP     = 3'b010,
        OP_AND     = 3'b011,
        OP_OR      = 3'b100,
        OP_XOR     = 3'b101,
        OP_ACC_ADD = 3'b110,
        OP_ACC_CLR = 3'b111
    } op_e;

    logic         r_out_valid;
    logic [W-1:0] r_result;
    logic         r_c_out;
    logic         r_gt;
    logic         r_eq;
    logic         r_lt;
    logic [W-1:0] r_acc;

    logic         w_accept;
    logic [W:0]   w_add;
    logic [W:0]   w_sub;
    logic [W:0]   w_acc_add;
    logic [W-1:0] w_result;
    logic         w_c_out;
    logic         w_gt;
    logic         w_eq;
    logic         w_lt;
    logic         w_acc_wr;
    logic [W-1:0] w_acc_nxt;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Carry is bit W of the (W+1)-bit sum; SUB carry of 1 means no borrow.
    assign w_add     = {1'b0, a} + {1'b0, b};
    assign w_sub     = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    assign w_acc_add = {1'b0, r_acc} + {1'b0, b};

    always_comb begin
        w_result  = '0;
        w_c_out   = 1'b0;
        w_gt      = 1'b0;
        w_eq      = 1'b0;
        w_lt      = 1'b0;
        w_acc_wr  = 1'b0;
        w_acc_nxt = r_acc;
        case (op_e'(op))
            OP_ADD: begin
                w_result = w_add[W-1:0];
                w_c_out  = w_add[W];
            end
            OP_SUB: begin
                w_result = w_sub[W-1:0];
                w_c_out  = w_sub[W];
            end
            OP_CMP: begin
                w_gt = (a > b);
                w_eq = (a == b);
                w_lt = (a < b);
            end
            OP_AND: w_result = a & b;
            OP_OR:  w_result = a | b;
            OP_XOR: w_result = a ^ b;
            OP_ACC_ADD: begin
                w_result  = w_acc_add[W-1:0];
                w_c_out   = w_acc_add[W];
                w_acc_wr  = 1'b1;
                w_acc_nxt = w_acc_add[W-1:0];
            end
            OP_ACC_CLR: begin
                w_acc_wr  = 1'b1;
                w_acc_nxt = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_c_out     <= 1'b0;
            r_gt        <= 1'b0;
            r_eq        <= 1'b0;
            r_lt        <= 1'b0;
            r_acc       <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_result;
            r_c_out     <= w_c_out;
            r_gt        <= w_gt;
            r_eq        <= w_eq;
            r_lt        <= w_lt;
            if (w_acc_wr) begin
                r_acc <= w_acc_nxt;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign c_out     = r_c_out;
    assign gt        = r_gt;
    assign eq        = r_eq;
    assign lt        = r_lt;
    assign zero      = (r_result == '0);
    assign acc       = r_acc;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at W=4; inputs change 1 time unit after each rising edge.
module tb_alu_pipe;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         c_out;
    logic         gt;
    logic         eq;
    logic         lt;
    logic         zero;
    logic [W-1:0] acc;

    int n_checks = 0;
    int n_fail   = 0;

    alu_pipe #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c_out     (c_out),
        .gt        (gt),
        .eq        (eq),
        .lt        (lt),
        .zero      (zero),
        .acc       (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic rdy);
        in_valid  = v;
        op        = o;
        a         = av;
        b         = bv;
        out_ready = rdy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
        step();
        step();
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_checks++; if (result !== 4'd0) begin n_fail++; $display("FAIL reset_result got %0d want 0", result); end
        n_checks++; if ({c_out, gt, eq, lt} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {c_out, gt, eq, lt}); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %0b want 1", zero); end
        n_checks++; if (acc !== 4'd0) begin n_fail++; $display("FAIL reset_acc got %0d want 0", acc); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_add();
        drive(1'b1, 3'b000, 4'd9, 4'd8, 1'b1);
        step();
        drive(1'b0, 3'b000, 4'd0, 4'd0, 1'b1);
        n_checks++; if (result !== 4'd1) begin n_fail++; $display("FAIL add_result got %0d want 1", result); end
        n_checks++; if (c_out !== 1'b1) begin n_fail++; $display("FAIL add_c_out got %0b want 1", c_out); end
        n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL add_zero got %0b want 0", zero); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_out_valid got %0b want 1", out_valid); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain got %0b want 0", out_valid); end
        n_checks++; if (result !== 4'd1) begin n_fail++; $display("FAIL add_idle_hold got %0d want 1", result); end
    endtask

    task automatic test_sub();
        drive(1'b1, 3'b001, 4'd3, 4'd5, 1'b1);
        step();
        n_checks++; if (result !== 4'd14) begin n_fail++; $display("FAIL sub35_result got %0d want 14", result); end
        n_checks++; if (c_out !== 1'b0) begin n_fail++; $display("FAIL sub35_c_out got %0b want 0", c_out); end
        drive(1'b1, 3'b001, 4'd5, 4'd5, 1'b1);
        step();
        drive(1'b0, 3'b000, 4'd0, 4'd0, 1'b1);
        n_checks++; if (result !== 4'd0) begin n_fail++; $display("FAIL sub55_result got %0d want 0", result); end
        n_checks++; if (c_out !== 1'b1) begin n_fail++; $display("FAIL sub55_c_out got %0b want 1", c_out); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL sub55_zero got %0b want 1", zero); end
        step();
    endtask

    task automatic test_cmp();
        drive(1'b1, 3'b010, 4'd7, 4'd2, 1'b1);
        step();
        n_checks++; if ({gt, eq, lt} !== 3'b100) begin n_fail++; $display("FAIL cmp72_flags got %b want 100", {gt, eq, lt}); end
        n_checks++; if (result !== 4'd0) begin n_fail++; $display("FAIL cmp72_result got %0d want 0", result); end
        n_checks++; if (c_out !== 1'b0) begin n_fail++; $display("FAIL cmp72_c_out got %0b want 0", c_out); end
        drive(1'b1, 3'b010, 4'd2, 4'd7, 1'b1);
        step();
        n_checks++; if ({gt, eq, lt} !== 3'b001) begin n_fail++; $display("FAIL cmp27_flags got %b want 001", {gt, eq, lt}); end
        drive(1'b1, 3'b011, 4'd12, 4'd10, 1'b1);
        step();
        drive(1'b0, 3'b000, 4'd0, 4'd0, 1'b1);
        n_checks++; if (result !== 4'd8) begin n_fail++; $display("FAIL and_result got %0d want 8", result); end
        n_checks++; if ({gt, eq, lt} !== 3'b000) begin n_fail++; $display("FAIL and_flags got %b want 000", {gt, eq, lt}); end
        step();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 3'b000, 4'd1, 4'd1, 1'b0);
        step();
        drive(1'b1, 3'b100, 4'd3, 4'd4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (result !== 4'd2) begin n_fail++; $display("FAIL bp_hold_result cyc %0d got %0d want 2", i, result); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc %0d got %0b want 0", i, in_ready); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cyc %0d got %0b want 1", i, out_valid); end
            step();
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %0b want 1", in_ready); end
        step();
        drive(1'b0, 3'b000, 4'd0, 4'd0, 1'b1);
        n_checks++; if (result !== 4'd7) begin n_fail++; $display("FAIL bp_or_result got %0d want 7", result); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_or_out_valid got %0b want 1", out_valid); end
        step();
    endtask

    task automatic test_back_to_back_acc();
        drive(1'b1, 3'b111, 4'd5, 4'd5, 1'b1);
        step();
        n_checks++; if (result !== 4'd0 || acc !== 4'd0) begin n_fail++; $display("FAIL acc_clr got result %0d acc %0d want 0 0", result, acc); end
        drive(1'b1, 3'b110, 4'd15, 4'd6, 1'b1);
        step();
        n_checks++; if (result !== 4'd6 || acc !== 4'd6 || c_out !== 1'b0) begin n_fail++; $display("FAIL acc_add6 got result %0d acc %0d c %0b want 6 6 0", result, acc, c_out); end
        drive(1'b1, 3'b110, 4'd15, 4'd11, 1'b1);
        step();
        n_checks++; if (result !== 4'd1 || acc !== 4'd1 || c_out !== 1'b1) begin n_fail++; $display("FAIL acc_add11 got result %0d acc %0d c %0b want 1 1 1", result, acc, c_out); end
        drive(1'b1, 3'b101, 4'd5, 4'd3, 1'b1);
        step();
        n_checks++; if (result !== 4'd6 || acc !== 4'd1) begin n_fail++; $display("FAIL xor_acc_hold got result %0d acc %0d want 6 1", result, acc); end
        drive(1'b0, 3'b111, 4'd0, 4'd0, 1'b1);
        step();
        n_checks++; if (acc !== 4'd1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_effect got acc %0d vld %0b want 1 0", acc, out_valid); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 3'b110, 4'd0, 4'd8, 1'b0);
        step();
        n_checks++; if (acc !== 4'd9 || out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst got acc %0d vld %0b want 9 1", acc, out_valid); end
        drive(1'b1, 3'b000, 4'd3, 4'd3, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 3'b000, 4'd0, 4'd0, 1'b1);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid got %0b want 0", out_valid); end
        n_checks++; if (acc !== 4'd0) begin n_fail++; $display("FAIL rst_mid_acc got %0d want 0", acc); end
        n_checks++; if (zero !== 1'b1 || result !== 4'd0) begin n_fail++; $display("FAIL rst_mid_zero got zero %0b result %0d want 1 0", zero, result); end
        step();
        n_checks++; if (out_valid !== 1'b0 || result !== 4'd0) begin n_fail++; $display("FAIL rst_mid_word_dropped got vld %0b result %0d want 0 0", out_valid, result); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_cmp();
        test_backpressure();
        test_back_to_back_acc();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
